// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder controller driving an external 4-bit ripple adder one nibble per cycle.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN (adds the in_sub_i port).
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic             in_cin_i,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             in_sub_i,
`endif
  output logic [3:0]       add_a_o,
  output logic [3:0]       add_b_o,
  output logic             add_cin_o,
  input  logic [3:0]       add_sum_i,
  input  logic             add_cout_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic             out_cout_o,
  output logic             busy_o
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             load_sub;
  logic [WIDTH-1:0] b_load_d;
  logic             carry_load_d;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign load_sub = in_sub_i;
`else
  assign load_sub = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so the inverted operand and forced carry are loaded up front.
  assign b_load_d     = in_b_i ^ {WIDTH{load_sub}};
  assign carry_load_d = in_cin_i | load_sub;
  assign accept       = (state_q == IDLE) && in_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            idx_q   <= '0;
            carry_q <= carry_load_d;
          end
        end
        RUN: begin
          carry_q <= add_cout_i;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand and result shift registers carry no reset; every output view of them is state-gated.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q <= in_a_i;
      b_q <= b_load_d;
    end else if (state_q == RUN) begin
      a_q      <= a_q >> 4;
      b_q      <= b_q >> 4;
      result_q <= {add_sum_i, result_q[WIDTH-1:4]};
    end
  end

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign busy_o      = (state_q == RUN) || (state_q == DONE);
  assign add_a_o     = (state_q == RUN) ? a_q[3:0] : 4'd0;
  assign add_b_o     = (state_q == RUN) ? b_q[3:0] : 4'd0;
  assign add_cin_o   = (state_q == RUN) ? carry_q : 1'b0;
  assign out_valid_o = (state_q == DONE);
  assign out_sum_o   = (state_q == DONE) ? result_q : '0;
  assign out_cout_o  = (state_q == DONE) ? carry_q : 1'b0;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a behavioural 4-bit adder closing the add_* loop.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic             in_sub;
`endif
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  end

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_cin_i    (in_cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .in_sub_i    (in_sub),
`endif
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_cin_o   (add_cin),
    .add_sum_i   (add_sum),
    .add_cout_i  (add_cout),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_cout_o  (out_cout),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; b_eff/cin_eff are what the adder should see (inverted B and carry 1 for subtract).
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b_eff,
                        input logic [WIDTH-1:0] b_in, input logic cin_in, input logic cin_eff,
                        input logic sub, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                        input int hold_cycles);
    int lat;
    logic [WIDTH-1:0] held;
    in_a = a;
    in_b = b_in;
    in_cin = cin_in;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    in_sub = sub;
`else
    if (sub) $display("note: subtract requested without subtract build");
`endif
    out_ready = 1'b0;
    in_valid = 1'b1;
    check("ready_before_accept", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    check("first_cin", add_cin, cin_eff);
    lat = 1;
    while (!out_valid && lat <= 20) begin
      check("add_a_nibble", add_a, (a >> (4 * (lat - 1))) & 4'hF);
      check("add_b_nibble", add_b, (b_eff >> (4 * (lat - 1))) & 4'hF);
      check("ready_low_run", in_ready, 0);
      cyc();
      lat++;
    end
    check("latency", lat - 1, 4);
    check("sum", out_sum, exp_sum);
    check("cout", out_cout, exp_cout);
    held = out_sum;
    for (int i = 0; i < hold_cycles; i++) begin
      in_valid = (i == 2);
      in_a = 16'hDEAD;
      in_b = 16'hBEEF;
      cyc();
      check("hold_sum", out_sum, held);
      check("hold_valid", out_valid, 1);
      check("hold_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("back_to_idle_valid", out_valid, 0);
    check("back_to_idle_ready", in_ready, 1);
    check("back_to_idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    in_sub = 1'b0;
`endif
    out_ready = 1'b0;
    repeat (3) cyc();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_busy", busy, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_cin", add_cin, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);
    cyc();
    check("idle_ready", in_ready, 1);
    check("idle_busy", busy, 0);

    // 0x1234 + 0x4321 = 0x5555; add_a walks 4,3,2,1
    run_op(16'h1234, 16'h4321, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 0);
    // full carry ripple two ways
    run_op(16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
    run_op(16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 0);
    // backpressure 5 cycles with an ignored in_valid pulse: 0x8001 + 0x0FFF = 0x9000
    run_op(16'h8001, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h9000, 1'b0, 5);

    // reset in the middle of a run
    in_a = 16'hAAAA;
    in_b = 16'h5555;
    in_cin = 1'b0;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    check("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_add_a", add_a, 0);
    check("mid_rst_add_cin", add_cin, 0);
    check("mid_rst_ready", in_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("mid_rst_release_ready", in_ready, 1);
    run_op(16'h0F0F, 16'h0101, 16'h0101, 1'b0, 1'b0, 1'b0, 16'h1010, 1'b0, 0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    run_op(16'h1000, 16'hFFFE, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0FFF, 1'b1, 0);
    run_op(16'h0000, 16'hFFFE, 16'h0001, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 0);
    run_op(16'h0005, 16'h0003, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0009, 1'b0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
